// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg: shared widths and FSM encodings for the fetch front-end sequencer.
package fetch_controller_pkg;
  localparam int WORD_WIDTH = 32;
  typedef enum logic [1:0] {
    FS_RESET_HOLD    = 2'd0,
    FS_FETCH         = 2'd1,
    FS_REDIRECT_WAIT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_stall_counter.sv
// fetch_stall_counter: saturating up-counter with enable, used for freeze-cycle statistics.
module fetch_stall_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (en && ~&count) count <= count + 1'b1;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: IF-stage sequencer for handshaked imem; FETCH_STALL_CNT_EN adds the stall counter.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hazard_detected,
  input  logic                  branch_taken_in,
  input  logic [WORD_WIDTH-1:0] branch_address_in,
  input  logic                  imem_ack,
  output logic                  imem_req,
  output logic                  freeze,
  output logic                  branch_taken,
  output logic [WORD_WIDTH-1:0] branch_address,
  output logic                  flush,
  output logic                  if_valid,
  output logic [CNT_WIDTH-1:0]  stall_count
);
  fetch_state_t state, state_nx;
  logic [WORD_WIDTH-1:0] pend_addr;
  logic pend_we;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= FS_RESET_HOLD;
      pend_addr <= '0;
    end else begin
      state <= state_nx;
      if (pend_we) pend_addr <= branch_address_in;
    end
  always_comb begin
    state_nx       = FS_RESET_HOLD;
    imem_req       = 1'b0;
    freeze         = 1'b1;
    branch_taken   = 1'b0;
    branch_address = '0;
    flush          = 1'b0;
    if_valid       = 1'b0;
    pend_we        = 1'b0;
    case (state)
      FS_RESET_HOLD: state_nx = FS_FETCH;
      FS_FETCH: begin
        imem_req = 1'b1;
        state_nx = FS_FETCH;
        if (branch_taken_in) begin
          flush = 1'b1;
          if (imem_ack) begin
            branch_taken   = 1'b1;
            branch_address = branch_address_in;
            freeze         = 1'b0;
          end else begin
            pend_we  = 1'b1;
            state_nx = FS_REDIRECT_WAIT;
          end
        end else if (!hazard_detected) begin
          freeze   = ~imem_ack;
          if_valid = imem_ack;
        end
      end
      FS_REDIRECT_WAIT: begin
        // the word in flight is wrong-path: drop it and redirect when it lands
        imem_req = 1'b1;
        pend_we  = branch_taken_in;
        flush    = branch_taken_in;
        state_nx = imem_ack ? FS_FETCH : FS_REDIRECT_WAIT;
        if (imem_ack) begin
          branch_taken   = 1'b1;
          branch_address = branch_taken_in ? branch_address_in : pend_addr;
          freeze         = 1'b0;
        end
      end
      default: state_nx = FS_RESET_HOLD;
    endcase
  end
`ifdef FETCH_STALL_CNT_EN
  fetch_stall_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (freeze && state != FS_RESET_HOLD),
    .count(stall_count)
  );
`else
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed self-checking bench for fetch_controller.
module tb_fetch_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_detected = 1'b0;
  logic branch_taken_in = 1'b0;
  logic [31:0] branch_address_in = '0;
  logic imem_ack = 1'b1;
  logic imem_req, freeze, branch_taken, flush, if_valid;
  logic [31:0] branch_address;
  logic [15:0] stall_count;
  int errors = 0;
  int checks = 0;

  fetch_controller dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .branch_taken_in(branch_taken_in), .branch_address_in(branch_address_in),
    .imem_ack(imem_ack), .imem_req(imem_req), .freeze(freeze),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .flush(flush), .if_valid(if_valid), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL rst_freeze: got %b want 1", freeze); end
    checks++; if ({branch_taken, flush, if_valid} !== 3'b000) begin errors++; $display("FAIL rst_outs: got %b want 000", {branch_taken, flush, if_valid}); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", stall_count); end
    checks++; if (dut.pend_addr !== 32'd0) begin errors++; $display("FAIL rst_pend: got %h want 0", dut.pend_addr); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({imem_req, freeze} !== 2'b01) begin errors++; $display("FAIL hold_cycle: got req,frz=%b want 01", {imem_req, freeze}); end
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({imem_req, freeze, if_valid} !== 3'b101) begin errors++; $display("FAIL zero_wait_%0d: got req,frz,vld=%b want 101", i, {imem_req, freeze, if_valid}); end
      step();
    end
  endtask

  task automatic test_wait_states();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({freeze, if_valid} !== 2'b10) begin errors++; $display("FAIL wait_%0d: got frz,vld=%b want 10", i, {freeze, if_valid}); end
      step();
    end
    imem_ack = 1'b1;
    @(negedge clk);
    checks++; if ({freeze, if_valid} !== 2'b01) begin errors++; $display("FAIL wait_ack: got frz,vld=%b want 01", {freeze, if_valid}); end
`ifdef FETCH_STALL_CNT_EN
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL stall_count: got %0d want 3", stall_count); end
`else
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL stall_count: got %0d want 0", stall_count); end
`endif
    step();
  endtask

  task automatic test_hazard();
    hazard_detected = 1'b1;
    @(negedge clk);
    checks++; if ({freeze, if_valid} !== 2'b10) begin errors++; $display("FAIL hazard: got frz,vld=%b want 10", {freeze, if_valid}); end
    step();
    hazard_detected = 1'b0;
    @(negedge clk);
    checks++; if ({freeze, if_valid} !== 2'b01) begin errors++; $display("FAIL hazard_release: got frz,vld=%b want 01", {freeze, if_valid}); end
    step();
  endtask

  task automatic test_branch_hit();
    branch_taken_in = 1'b1;
    branch_address_in = 32'h40;
    @(negedge clk);
    checks++; if ({branch_taken, flush, if_valid, freeze} !== 4'b1100) begin errors++; $display("FAIL br_hit_ctl: got bt,fl,vld,frz=%b want 1100", {branch_taken, flush, if_valid, freeze}); end
    checks++; if (branch_address !== 32'h40) begin errors++; $display("FAIL br_hit_addr: got %h want 40", branch_address); end
    step();
    branch_taken_in = 1'b0;
    branch_address_in = '0;
    @(negedge clk);
    checks++; if ({branch_taken, flush, if_valid} !== 3'b001) begin errors++; $display("FAIL br_hit_after: got bt,fl,vld=%b want 001", {branch_taken, flush, if_valid}); end
    step();
  endtask

  task automatic test_branch_wait();
    branch_taken_in = 1'b1;
    branch_address_in = 32'h80;
    imem_ack = 1'b0;
    @(negedge clk);
    checks++; if ({branch_taken, flush, freeze, if_valid} !== 4'b0110) begin errors++; $display("FAIL brw_entry: got bt,fl,frz,vld=%b want 0110", {branch_taken, flush, freeze, if_valid}); end
    step();
    branch_taken_in = 1'b0;
    branch_address_in = 32'h1234;
    @(negedge clk);
    checks++; if (dut.state !== 2'd2) begin errors++; $display("FAIL brw_state: got %0d want 2", dut.state); end
    checks++; if ({branch_taken, flush, freeze, imem_req} !== 4'b0011) begin errors++; $display("FAIL brw_wait: got bt,fl,frz,req=%b want 0011", {branch_taken, flush, freeze, imem_req}); end
    step();
    imem_ack = 1'b1;
    @(negedge clk);
    checks++; if ({branch_taken, if_valid, freeze, flush} !== 4'b1000) begin errors++; $display("FAIL brw_ack: got bt,vld,frz,fl=%b want 1000", {branch_taken, if_valid, freeze, flush}); end
    checks++; if (branch_address !== 32'h80) begin errors++; $display("FAIL brw_addr: got %h want 80", branch_address); end
    step();
    branch_address_in = '0;
    @(negedge clk);
    checks++; if ({branch_taken, if_valid} !== 2'b01) begin errors++; $display("FAIL brw_resume: got bt,vld=%b want 01", {branch_taken, if_valid}); end
    step();
  endtask

  task automatic test_back_to_back();
    branch_taken_in = 1'b1;
    branch_address_in = 32'h80;
    imem_ack = 1'b0;
    step();
    branch_address_in = 32'hC0;
    @(negedge clk);
    checks++; if ({flush, freeze, branch_taken} !== 3'b110) begin errors++; $display("FAIL b2b_second: got fl,frz,bt=%b want 110", {flush, freeze, branch_taken}); end
    step();
    branch_taken_in = 1'b0;
    branch_address_in = '0;
    checks++; if (dut.pend_addr !== 32'hC0) begin errors++; $display("FAIL b2b_pend: got %h want c0", dut.pend_addr); end
    imem_ack = 1'b1;
    @(negedge clk);
    checks++; if (branch_taken !== 1'b1 || branch_address !== 32'hC0) begin errors++; $display("FAIL b2b_redirect: got bt=%b addr=%h want 1 c0", branch_taken, branch_address); end
    step();
    branch_taken_in = 1'b1;
    branch_address_in = 32'h100;
    imem_ack = 1'b0;
    step();
    branch_address_in = 32'h140;
    imem_ack = 1'b1;
    @(negedge clk);
    checks++; if ({branch_taken, flush, freeze} !== 3'b110 || branch_address !== 32'h140) begin errors++; $display("FAIL b2b_direct: got bt,fl,frz=%b addr=%h want 110 140", {branch_taken, flush, freeze}, branch_address); end
    step();
    branch_taken_in = 1'b0;
    branch_address_in = '0;
    @(negedge clk);
    checks++; if (dut.state !== 2'd1) begin errors++; $display("FAIL b2b_state: got %0d want 1", dut.state); end
    step();
  endtask

  task automatic test_reset_mid_wait();
    branch_taken_in = 1'b1;
    branch_address_in = 32'h200;
    imem_ack = 1'b0;
    step();
    branch_taken_in = 1'b0;
    branch_address_in = '0;
    @(negedge clk);
    checks++; if (dut.state !== 2'd2) begin errors++; $display("FAIL rmw_state: got %0d want 2", dut.state); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({imem_req, freeze, branch_taken} !== 3'b010) begin errors++; $display("FAIL rmw_async: got req,frz,bt=%b want 010", {imem_req, freeze, branch_taken}); end
    checks++; if (dut.pend_addr !== 32'd0) begin errors++; $display("FAIL rmw_pend: got %h want 0", dut.pend_addr); end
    step();
    rst = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    checks++; if ({imem_req, freeze} !== 2'b01) begin errors++; $display("FAIL rmw_hold: got req,frz=%b want 01", {imem_req, freeze}); end
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({branch_taken, if_valid, freeze} !== 3'b010) begin errors++; $display("FAIL rmw_after_%0d: got bt,vld,frz=%b want 010", i, {branch_taken, if_valid, freeze}); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_hazard();
    test_branch_hit();
    test_branch_wait();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
